// File: rtl/key_bcd_counter.sv
// key_bcd_counter
//   Debounces one active-low pushbutton and counts accepted presses in a three-digit BCD
//   counter (000-999). The counter steps up or down according to a switch. The module
//   drives the digit inputs of the board's seven-segment decoders.
//
// Optional feature (macro KEY_BCD_COUNTER_AUTO_REPEAT_EN):
//   While the key stays debounced-pressed, extra press strobes are generated.
//   The first comes after REPEAT_DELAY cycles and later ones every REPEAT_PERIOD cycles.
//
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   key_n       in   raw pushbutton, low = pressed, asynchronous to clk
//   up          in   count direction, 1 = up, 0 = down, raw switch level
//   clear       in   synchronous clear of the count (has priority over a press)
//   bcd0        out  ones digit
//   bcd1        out  tens digit
//   bcd2        out  hundreds digit
//   press_pulse out  one-cycle strobe per accepted press
//   wrap        out  one-cycle strobe when the count wraps 999->000 or 000->999
module key_bcd_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_n,
    input  logic       up,
    input  logic       clear,
    output logic [3:0] bcd0,
    output logic [3:0] bcd1,
    output logic [3:0] bcd2,
    output logic       press_pulse,
    output logic       wrap
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StPressed,
        StReleaseWait
    } state_e;

    // Two-flop synchronisers; key idles released (1), direction idles down (0).
    logic key_meta_q, key_s_q;
    logic up_meta_q, up_s_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_meta_q <= 1'b1;
            key_s_q    <= 1'b1;
            up_meta_q  <= 1'b0;
            up_s_q     <= 1'b0;
        end else begin
            key_meta_q <= key_n;
            key_s_q    <= key_meta_q;
            up_meta_q  <= up;
            up_s_q     <= up_meta_q;
        end
    end

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pulse_q, pulse_d;

`ifdef KEY_BCD_COUNTER_AUTO_REPEAT_EN
    localparam int unsigned HoldMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned HoldW = $clog2(HoldMax + 1);
    localparam logic [HoldW-1:0] DelayLast  = HoldW'(REPEAT_DELAY - 1);
    localparam logic [HoldW-1:0] PeriodLast = HoldW'(REPEAT_PERIOD - 1);

    logic [HoldW-1:0] hold_q, hold_d;
    // Set once the first repeat has fired; later repeats use the shorter period.
    logic             rep_q, rep_d;
`else
    logic unused_repeat_params;
    assign unused_repeat_params = (REPEAT_DELAY == REPEAT_PERIOD);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
`ifdef KEY_BCD_COUNTER_AUTO_REPEAT_EN
        // Anything other than staying in StPressed clears the hold timer.
        hold_d  = '0;
        rep_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (!key_s_q) begin
                    state_d = StPressWait;
                    cnt_d   = CntW'(1);
                end
            end
            StPressWait: begin
                if (key_s_q) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StPressed: begin
                if (key_s_q) begin
                    state_d = StReleaseWait;
                    cnt_d   = CntW'(1);
                end else begin
`ifdef KEY_BCD_COUNTER_AUTO_REPEAT_EN
                    rep_d = rep_q;
                    if (hold_q == (rep_q ? PeriodLast : DelayLast)) begin
                        pulse_d = 1'b1;
                        hold_d  = '0;
                        rep_d   = 1'b1;
                    end else begin
                        hold_d = hold_q + HoldW'(1);
                    end
`endif
                end
            end
            StReleaseWait: begin
                if (!key_s_q) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

`ifdef KEY_BCD_COUNTER_AUTO_REPEAT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '0;
            rep_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end
`endif

    // BCD counter: digits ripple directly in BCD, stepping on the edge that ends the strobe.
    logic [3:0] bcd0_q, bcd0_d, bcd1_q, bcd1_d, bcd2_q, bcd2_d;
    logic       wrap_q, wrap_d;

    always_comb begin
        bcd0_d = bcd0_q;
        bcd1_d = bcd1_q;
        bcd2_d = bcd2_q;
        wrap_d = 1'b0;
        if (clear) begin
            bcd0_d = 4'd0;
            bcd1_d = 4'd0;
            bcd2_d = 4'd0;
        end else if (pulse_q) begin
            if (up_s_q) begin
                if (bcd0_q != 4'd9) begin
                    bcd0_d = bcd0_q + 4'd1;
                end else begin
                    bcd0_d = 4'd0;
                    if (bcd1_q != 4'd9) begin
                        bcd1_d = bcd1_q + 4'd1;
                    end else begin
                        bcd1_d = 4'd0;
                        if (bcd2_q != 4'd9) begin
                            bcd2_d = bcd2_q + 4'd1;
                        end else begin
                            bcd2_d = 4'd0;
                            wrap_d = 1'b1;
                        end
                    end
                end
            end else begin
                if (bcd0_q != 4'd0) begin
                    bcd0_d = bcd0_q - 4'd1;
                end else begin
                    bcd0_d = 4'd9;
                    if (bcd1_q != 4'd0) begin
                        bcd1_d = bcd1_q - 4'd1;
                    end else begin
                        bcd1_d = 4'd9;
                        if (bcd2_q != 4'd0) begin
                            bcd2_d = bcd2_q - 4'd1;
                        end else begin
                            bcd2_d = 4'd9;
                            wrap_d = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcd0_q <= 4'd0;
            bcd1_q <= 4'd0;
            bcd2_q <= 4'd0;
            wrap_q <= 1'b0;
        end else begin
            bcd0_q <= bcd0_d;
            bcd1_q <= bcd1_d;
            bcd2_q <= bcd2_d;
            wrap_q <= wrap_d;
        end
    end

    assign bcd0        = bcd0_q;
    assign bcd1        = bcd1_q;
    assign bcd2        = bcd2_q;
    assign press_pulse = pulse_q;
    assign wrap        = wrap_q;

endmodule

// File: tb/tb_key_bcd_counter.sv
// Testbench for key_bcd_counter with a run-length debounce model and an integer count model.
module tb_key_bcd_counter;

    localparam int unsigned D  = 4;
    localparam int unsigned RD = 20;
    localparam int unsigned RP = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       key_n = 1'b1;
    logic       up = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] bcd0, bcd1, bcd2;
    logic       press_pulse, wrap;

    int vectors = 0;
    int miscompares = 0;

    key_bcd_counter #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_n      (key_n),
        .up         (up),
        .clear      (clear),
        .bcd0       (bcd0),
        .bcd1       (bcd1),
        .bcd2       (bcd2),
        .press_pulse(press_pulse),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    // Reference model: the key is accepted as changed once D+1 consecutive synchronised
    // samples disagree with the accepted level; the count is a plain integer mod 1000.
    bit kp0, kp1, up0, up1, ks, us;
    bit acc_pressed, want_pressed, was_held, fire;
    int run, held, m_count;
    bit m_pulse, m_wrap;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kp0 = 1; kp1 = 1; up0 = 0; up1 = 0;
            acc_pressed = 0; run = 0; held = 0;
            m_count = 0; m_pulse = 0; m_wrap = 0;
        end else begin
            ks = kp1; us = up1;
            kp1 = kp0; kp0 = key_n; up1 = up0; up0 = up;
            if (clear) begin
                m_count = 0; m_wrap = 0;
            end else if (m_pulse) begin
                if (us) begin
                    m_wrap = (m_count == 999); m_count = (m_count + 1) % 1000;
                end else begin
                    m_wrap = (m_count == 0); m_count = (m_count + 999) % 1000;
                end
            end else begin
                m_wrap = 0;
            end
            was_held = acc_pressed && (run == 0);
            fire = 0;
            want_pressed = (ks == 1'b0);
            if (want_pressed != acc_pressed) run++;
            else run = 0;
            if (run == int'(D) + 1) begin
                acc_pressed = want_pressed;
                run = 0;
                if (acc_pressed) fire = 1;
            end
`ifdef KEY_BCD_COUNTER_AUTO_REPEAT_EN
            if (was_held && acc_pressed && run == 0) begin
                held++;
                if (held == int'(RD) || (held > int'(RD) && (held - int'(RD)) % int'(RP) == 0))
                    fire = 1;
            end else begin
                held = 0;
            end
`endif
            m_pulse = fire;
        end
    end

    function automatic logic [13:0] exp_vec();
        return {4'(m_count / 100), 4'((m_count / 10) % 10), 4'(m_count % 10), m_pulse, m_wrap};
    endfunction

    function automatic logic [13:0] got_vec();
        return {bcd2, bcd1, bcd0, press_pulse, wrap};
    endfunction

    // One clock: apply inputs, step past the rising edge, settle.
    task automatic cyc(input bit k, input bit u, input bit c);
        key_n = k; up = u; clear = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (got_vec() !== 14'h0) begin
            miscompares++;
            $display("FAIL reset_values: got %h expected %h", got_vec(), 14'h0);
        end
        reset_n = 1;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0);
            vectors++;
            if (got_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_idle cyc %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_single_press();
        int pulses = 0, at = -1;
        for (int i = 0; i < 32; i++) begin
            cyc(i < 20 ? 1'b0 : 1'b1, 1, 0);
            vectors++;
            if (got_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL single_press cyc %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
            if (press_pulse) begin pulses++; at = i; end
            if (i == 7) begin
                vectors++;
                if ({bcd2, bcd1, bcd0} !== 12'h001) begin
                    miscompares++;
                    $display("FAIL single_press_digits: got %h expected 001", {bcd2, bcd1, bcd0});
                end
            end
        end
        vectors++;
        if (pulses != 1 || at != 6) begin
            miscompares++;
            $display("FAIL single_press_latency: got %0d pulses at %0d, expected 1 at 6", pulses, at);
        end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        int start = m_count;
        for (int g = 0; g < 5; g++) begin
            for (int i = 0; i < 5; i++) begin
                cyc(i < 3 ? 1'b0 : 1'b1, 1, 0);
                vectors++;
                if (got_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL glitch cyc %0d/%0d: got %h expected %h", g, i, got_vec(), exp_vec());
                end
                if (press_pulse) pulses++;
            end
        end
        repeat (8) cyc(1, 1, 0);
        vectors++;
        if (pulses != 0 || m_count != start) begin
            miscompares++;
            $display("FAIL glitch_rejected: got %0d pulses, expected 0", pulses);
        end
    endtask

    task automatic test_wrap();
        int wraps, guard;
        guard = 0;
        while (m_count != 999 && guard < 1100) begin
            guard++;
            for (int i = 0; i < 13; i++) begin
                cyc(i < 6 ? 1'b0 : 1'b1, 1, 0);
                vectors++;
                if (got_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL preload cyc %0d: got %h expected %h", i, got_vec(), exp_vec());
                end
            end
        end
        vectors++;
        if ({bcd2, bcd1, bcd0} !== 12'h999) begin
            miscompares++;
            $display("FAIL preload_999: got %h expected 999", {bcd2, bcd1, bcd0});
        end
        for (int dir = 1; dir >= 0; dir--) begin
            wraps = 0;
            for (int i = 0; i < 13; i++) begin
                cyc(i < 6 ? 1'b0 : 1'b1, dir[0], 0);
                vectors++;
                if (got_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL wrap dir %0d cyc %0d: got %h expected %h", dir, i, got_vec(), exp_vec());
                end
                if (wrap) wraps++;
            end
            vectors++;
            if (wraps != 1 || {bcd2, bcd1, bcd0} !== (dir == 1 ? 12'h000 : 12'h999)) begin
                miscompares++;
                $display("FAIL wrap_result dir %0d: got %h with %0d wraps, expected %s with 1",
                         dir, {bcd2, bcd1, bcd0}, wraps, dir == 1 ? "000" : "999");
            end
        end
    endtask

    task automatic test_clear();
        int wraps = 0;
        cyc(1, 1, 1);
        vectors++;
        if ({bcd2, bcd1, bcd0, wrap} !== 13'h0) begin
            miscompares++;
            $display("FAIL clear_initial: got %h expected 0000", {bcd2, bcd1, bcd0, wrap});
        end
        for (int p = 0; p < 42 + 1; p++) begin
            for (int i = 0; i < 13; i++) begin
                // On the last press, clear is raised exactly during the strobe cycle.
                cyc(i < 6 ? 1'b0 : 1'b1, 1, (p == 42) ? m_pulse : 1'b0);
                vectors++;
                if (got_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL clear_press %0d cyc %0d: got %h expected %h", p, i, got_vec(), exp_vec());
                end
                if (p == 42 && wrap) wraps++;
            end
            if (p == 41) begin
                vectors++;
                if ({bcd2, bcd1, bcd0} !== 12'h042) begin
                    miscompares++;
                    $display("FAIL count_042: got %h expected 042", {bcd2, bcd1, bcd0});
                end
            end
        end
        vectors++;
        if ({bcd2, bcd1, bcd0} !== 12'h000 || wraps != 0) begin
            miscompares++;
            $display("FAIL clear_in_pulse: got %h with %0d wraps, expected 000 with 0",
                     {bcd2, bcd1, bcd0}, wraps);
        end
        for (int p = 0; p < 17; p++) begin
            for (int i = 0; i < 13; i++) begin
                cyc(i < 6 ? 1'b0 : 1'b1, 1, 0);
                vectors++;
                if (got_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL count_up %0d cyc %0d: got %h expected %h", p, i, got_vec(), exp_vec());
                end
            end
        end
        vectors++;
        if ({bcd2, bcd1, bcd0} !== 12'h017) begin
            miscompares++;
            $display("FAIL count_017: got %h expected 017", {bcd2, bcd1, bcd0});
        end
        cyc(1, 1, 1);
        vectors++;
        if ({bcd2, bcd1, bcd0} !== 12'h000) begin
            miscompares++;
            $display("FAIL clear_alone: got %h expected 000", {bcd2, bcd1, bcd0});
        end
        clear = 0;
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        repeat (4) cyc(0, 1, 0);
        #2 reset_n = 0;
        #1;
        vectors++;
        if ({press_pulse, wrap, bcd2, bcd1, bcd0} !== 14'h0) begin
            miscompares++;
            $display("FAIL reset_mid_async: got %h expected 0", {press_pulse, wrap, bcd2, bcd1, bcd0});
        end
        repeat (3) cyc(0, 1, 0);
        reset_n = 1;
        for (int i = 0; i < 24; i++) begin
            cyc(i < 12 ? 1'b0 : 1'b1, 1, 0);
            vectors++;
            if (got_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_mid cyc %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
            if (press_pulse) pulses++;
        end
        vectors++;
        if (pulses != 1 || {bcd2, bcd1, bcd0} !== 12'h001) begin
            miscompares++;
            $display("FAIL reset_mid_count: got %h with %0d pulses, expected 001 with 1",
                     {bcd2, bcd1, bcd0}, pulses);
        end
    endtask

    task automatic test_auto_repeat();
`ifdef KEY_BCD_COUNTER_AUTO_REPEAT_EN
        int exp_times[$] = '{0, 20, 28, 36, 44};
`else
        int exp_times[$] = '{0};
`endif
        int times[$];
        int start, k, guard;
        start = m_count;
        guard = 0;
        k = -1;
        while (k < 44) begin
            cyc(0, 1, 0);
            vectors++;
            if (got_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL auto_repeat cyc %0d: got %h expected %h", k, got_vec(), exp_vec());
            end
            if (k >= 0) k++;
            if (press_pulse) begin
                if (k < 0) k = 0;
                times.push_back(k);
            end
            guard++;
            if (k < 0 && guard > 20) begin
                miscompares++;
                $display("FAIL auto_repeat_timeout: got no pulse in 20 cycles, expected one");
                k = 44;
            end
        end
        for (int i = 0; i < 16; i++) begin
            cyc(1, 1, 0);
            vectors++;
            if (got_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL auto_release cyc %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
            if (press_pulse) times.push_back(45 + i);
        end
        vectors++;
        if (times != exp_times) begin
            miscompares++;
            $display("FAIL auto_repeat_times: got %p expected %p", times, exp_times);
        end
        vectors++;
        if ({bcd2, bcd1, bcd0} !== {4'(((start + exp_times.size()) % 1000) / 100),
                                    4'(((start + exp_times.size()) / 10) % 10),
                                    4'((start + exp_times.size()) % 10)}) begin
            miscompares++;
            $display("FAIL auto_repeat_count: got %h expected start %0d + %0d",
                     {bcd2, bcd1, bcd0}, start, exp_times.size());
        end
    endtask

    task automatic test_random();
        bit k = 1, u = 1;
        int len;
        for (int seg = 0; seg < 300; seg++) begin
            k = ~k;
            if ($urandom_range(0, 3) == 0) u = ~u;
            len = $urandom_range(1, 9);
            for (int i = 0; i < len; i++) begin
                cyc(k, u, $urandom_range(0, 39) == 0);
                vectors++;
                if (got_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL random seg %0d cyc %0d: got %h expected %h", seg, i, got_vec(), exp_vec());
                end
            end
        end
        clear = 0;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_wrap();
        test_clear();
        test_reset_mid();
        test_auto_repeat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
